axi_gpu_reg_file: RTL

Native AXI4 slave register file for the GPU control plane. It decodes AXI4 bursts directly, with no intermediate BRAM-style port. It provides a parametrised bank of read/write control registers and a bank of read-only status registers. It drives the GPU core's control inputs, such as command-processor X/Y and index, and exposes GPU status to the PS. Optional shadowing defers register updates to a frame-sync strobe.

---
 rtl/gpu_reg_pkg.sv | 32 +++
 rtl/gpu_reg_burst_addr.sv | 44 ++++
 rtl/axi_gpu_reg_file.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_reg_pkg.sv
// rtl/gpu_reg_pkg.sv - shared AXI codes, FSM states and register indices for the GPU register file
package gpu_reg_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  localparam int REG_CP_X  = 0;
  localparam int REG_CP_Y  = 1;
  localparam int REG_INDEX = 2;

endpackage

// File: rtl/gpu_reg_burst_addr.sv
// rtl/gpu_reg_burst_addr.sv - per-channel AXI burst word index and beat counter
module gpu_reg_burst_addr import gpu_reg_pkg::*; #(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [7:0]       load_len,
  input  logic [1:0]       load_burst,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_next,
  output logic             last,
  output logic             last_next,
  output logic             wrap_err
);

  logic [7:0] remain;
  logic       fixed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      remain   <= '0;
      fixed    <= 1'b0;
      wrap_err <= 1'b0;
    end else if (load) begin
      idx      <= load_idx;
      remain   <= load_len;
      fixed    <= (load_burst == BURST_FIXED);
      wrap_err <= (load_burst == BURST_WRAP);
    end else if (step) begin
      idx    <= idx_next;
      remain <= remain - 8'd1;
    end
  end

  // WRAP bursts step like INCR; the index rolls over at the top of the word space
  assign idx_next  = fixed ? idx : idx + IDX_W'(1);
  assign last      = (remain == 8'd0);
  assign last_next = (remain == 8'd1);

endmodule

// File: rtl/axi_gpu_reg_file.sv
// rtl/axi_gpu_reg_file.sv - AXI4 slave GPU control/status register file
// Optional GPU_REG_SHADOW_EN defers regs_o updates to frame_sync_i.
module axi_gpu_reg_file import gpu_reg_pkg::*; #(
  parameter int NUM_REGS   = 8,
  parameter int NUM_STATUS = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]            S_AXI_awaddr,
  input  logic [7:0]                       S_AXI_awlen,
  input  logic [2:0]                       S_AXI_awsize,
  input  logic [1:0]                       S_AXI_awburst,
  input  logic                             S_AXI_awlock,
  input  logic [3:0]                       S_AXI_awcache,
  input  logic [2:0]                       S_AXI_awprot,
  input  logic                             S_AXI_awvalid,
  output logic                             S_AXI_awready,
  input  logic [DATA_WIDTH-1:0]            S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0]          S_AXI_wstrb,
  input  logic                             S_AXI_wlast,
  input  logic                             S_AXI_wvalid,
  output logic                             S_AXI_wready,
  output logic [1:0]                       S_AXI_bresp,
  output logic                             S_AXI_bvalid,
  input  logic                             S_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]            S_AXI_araddr,
  input  logic [7:0]                       S_AXI_arlen,
  input  logic [2:0]                       S_AXI_arsize,
  input  logic [1:0]                       S_AXI_arburst,
  input  logic                             S_AXI_arlock,
  input  logic [3:0]                       S_AXI_arcache,
  input  logic [2:0]                       S_AXI_arprot,
  input  logic                             S_AXI_arvalid,
  output logic                             S_AXI_arready,
  output logic [DATA_WIDTH-1:0]            S_AXI_rdata,
  output logic [1:0]                       S_AXI_rresp,
  output logic                             S_AXI_rlast,
  output logic                             S_AXI_rvalid,
  input  logic                             S_AXI_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   regs_o,
  input  logic [NUM_STATUS*DATA_WIDTH-1:0] status_i,
  input  logic                             frame_sync_i
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] RW_END  = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0] MAP_END = IDX_W'(NUM_REGS + NUM_STATUS);

  w_state_t w_state;
  r_state_t r_state;

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic [IDX_W-1:0] wr_idx, wr_idx_next, rd_idx, rd_idx_next;
  logic wr_last, wr_last_next, wr_wrap_err;
  logic rd_last, rd_last_next, rd_wrap_err;

  assign S_AXI_awready = (w_state == W_IDLE);
  assign S_AXI_wready  = (w_state == W_DATA);
  assign S_AXI_bvalid  = (w_state == W_RESP);
  assign S_AXI_arready = (r_state == R_IDLE);
  assign S_AXI_rvalid  = (r_state == R_DATA);

  assign aw_hs = S_AXI_awvalid & S_AXI_awready;
  assign w_hs  = S_AXI_wvalid & S_AXI_wready;
  assign ar_hs = S_AXI_arvalid & S_AXI_arready;
  assign r_hs  = S_AXI_rvalid & S_AXI_rready;

  gpu_reg_burst_addr #(.IDX_W(IDX_W)) u_wr_addr (
    .clk        (s_axi_aclk),
    .rst_n      (s_axi_aresetn),
    .load       (aw_hs),
    .step       (w_hs),
    .load_idx   (S_AXI_awaddr[ADDR_WIDTH-1:2]),
    .load_len   (S_AXI_awlen),
    .load_burst (S_AXI_awburst),
    .idx        (wr_idx),
    .idx_next   (wr_idx_next),
    .last       (wr_last),
    .last_next  (wr_last_next),
    .wrap_err   (wr_wrap_err)
  );

  gpu_reg_burst_addr #(.IDX_W(IDX_W)) u_rd_addr (
    .clk        (s_axi_aclk),
    .rst_n      (s_axi_aresetn),
    .load       (ar_hs),
    .step       (r_hs & ~rd_last),
    .load_idx   (S_AXI_araddr[ADDR_WIDTH-1:2]),
    .load_len   (S_AXI_arlen),
    .load_burst (S_AXI_arburst),
    .idx        (rd_idx),
    .idx_next   (rd_idx_next),
    .last       (rd_last),
    .last_next  (rd_last_next),
    .wrap_err   (rd_wrap_err)
  );

  // Write channel: the beat counter ends the burst, wlast only feeds the error flag
  logic wr_err, wr_beat_err, wr_en;
  assign wr_beat_err = (wr_idx >= RW_END) | (S_AXI_wlast != wr_last);
  assign wr_en       = w_hs & (wr_idx < RW_END);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state     <= W_IDLE;
      wr_err      <= 1'b0;
      S_AXI_bresp <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          w_state <= W_DATA;
          wr_err  <= 1'b0;
        end
        W_DATA: if (w_hs) begin
          wr_err <= wr_err | wr_beat_err;
          if (wr_last) begin
            w_state     <= W_RESP;
            S_AXI_bresp <= (wr_err | wr_beat_err | wr_wrap_err) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        W_RESP: if (S_AXI_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] store_q   [NUM_REGS];
  logic [DATA_WIDTH-1:0] store_nxt [NUM_REGS];

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      store_nxt[k] = store_q[k];
      if (wr_en && wr_idx == IDX_W'(k)) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
          if (S_AXI_wstrb[b]) store_nxt[k][8*b +: 8] = S_AXI_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int k = 0; k < NUM_REGS; k++) store_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) store_q[k] <= store_nxt[k];
    end
  end

`ifdef GPU_REG_SHADOW_EN
  // store_q is the shadow; committing store_nxt folds a same-cycle beat into the frame
  logic [DATA_WIDTH-1:0] live_q [NUM_REGS];

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int k = 0; k < NUM_REGS; k++) live_q[k] <= '0;
    end else if (frame_sync_i) begin
      for (int k = 0; k < NUM_REGS; k++) live_q[k] <= store_nxt[k];
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = live_q[k];
  end
`else
  logic unused_frame_sync;
  assign unused_frame_sync = frame_sync_i;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = store_q[k];
  end
`endif

  // Read channel: each beat is formed one cycle ahead from the registered store
  logic [IDX_W-1:0]      rd_form_idx;
  logic                  rd_form_wrap, rd_unmapped;
  logic [DATA_WIDTH-1:0] rd_word;

  assign rd_form_idx  = (r_state == R_IDLE) ? S_AXI_araddr[ADDR_WIDTH-1:2] : rd_idx_next;
  assign rd_form_wrap = (r_state == R_IDLE) ? (S_AXI_arburst == BURST_WRAP) : rd_wrap_err;

  always_comb begin
    rd_word     = '0;
    rd_unmapped = (rd_form_idx >= MAP_END);
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_form_idx == IDX_W'(k)) rd_word = store_q[k];
    end
    for (int s = 0; s < NUM_STATUS; s++) begin
      if (rd_form_idx == IDX_W'(NUM_REGS + s)) rd_word = status_i[s*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state     <= R_IDLE;
      S_AXI_rdata <= '0;
      S_AXI_rresp <= RESP_OKAY;
      S_AXI_rlast <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          r_state     <= R_DATA;
          S_AXI_rdata <= rd_word;
          S_AXI_rresp <= (rd_unmapped | rd_form_wrap) ? RESP_SLVERR : RESP_OKAY;
          S_AXI_rlast <= (S_AXI_arlen == 8'd0);
        end
        R_DATA: if (r_hs) begin
          if (rd_last) begin
            r_state     <= R_IDLE;
            S_AXI_rlast <= 1'b0;
          end else begin
            S_AXI_rdata <= rd_word;
            S_AXI_rresp <= (rd_unmapped | rd_form_wrap) ? RESP_SLVERR : RESP_OKAY;
            S_AXI_rlast <= rd_last_next;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_awsize, S_AXI_awlock, S_AXI_awcache, S_AXI_awprot, S_AXI_awaddr[1:0],
                       S_AXI_arsize, S_AXI_arlock, S_AXI_arcache, S_AXI_arprot, S_AXI_araddr[1:0],
                       wr_idx_next, wr_last_next, rd_idx};

endmodule
